// File: rtl/spi_to_uart_bridge.sv
// SPI mode-0 slave that queues each received byte in a FIFO and replays it on an 8N1 UART TX line.
// MISO returns the last complete byte received; everything runs on system_clk.
module spi_to_uart_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic system_clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // [0],[1] form the synchroniser; [2] holds the previous synchronised value for edge detection
  logic [2:0] r_sclk_sync;
  logic [2:0] r_cs_sync;
  logic [1:0] r_mosi_sync;

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 2'b00;
    end else begin
      r_sclk_sync <= {r_sclk_sync[1:0], sclk};
      r_cs_sync   <= {r_cs_sync[1:0], cs};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_cs_low, w_cs_fall;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_low    = ~r_cs_sync[1];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];

  logic [6:0] r_shift_in;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_reply;
  logic [7:0] r_shift_out;
  logic [7:0] w_rx_byte;
  logic       w_byte_done;

  assign w_rx_byte   = {r_shift_in, r_mosi_sync[1]};
  assign w_byte_done = w_cs_low & w_sclk_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_shift_in <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_reply    <= 8'd0;
    end else if (!w_cs_low) begin
      r_bit_cnt <= 3'd0;
    end else if (w_sclk_rise) begin
      r_shift_in <= w_rx_byte[6:0];
      r_bit_cnt  <= r_bit_cnt + 3'd1;
      if (r_bit_cnt == 3'd7) r_reply <= w_rx_byte;
    end
  end

  // A falling edge with the counter back at 0 ends a byte: reload with the byte just received
  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_shift_out <= 8'd0;
    end else if (w_cs_fall) begin
      r_shift_out <= r_reply;
    end else if (w_cs_low && w_sclk_fall) begin
      if (r_bit_cnt == 3'd0) r_shift_out <= r_reply;
      else                   r_shift_out <= {r_shift_out[6:0], 1'b0};
    end
  end

  assign miso = w_cs_low & r_shift_out[7];

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [1:0]  r_state;
  logic        w_empty, w_full, w_push, w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = w_byte_done & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;

  always_ff @(posedge system_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  logic [BW-1:0] r_baud_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_byte;
  logic          r_tx;

  always_ff @(posedge system_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_tx_bit   <= 3'd0;
      r_tx_byte  <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_baud_cnt <= '0;
          r_tx_bit   <= 3'd0;
          r_tx       <= 1'b1;
          if (w_pop) begin
            r_tx_byte <= r_mem[r_rd_ptr[AW-1:0]];
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_tx       <= r_tx_byte[0];
            r_state    <= S_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        S_DATA: begin
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_tx_byte  <= {1'b0, r_tx_byte[7:1]};
            if (r_tx_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx     <= r_tx_byte[1];
              r_tx_bit <= r_tx_bit + 3'd1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
        default: begin
          r_tx <= 1'b1;
          if (r_baud_cnt == BAUD_LAST) begin
            r_baud_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + BW'(1);
          end
        end
      endcase
    end
  end

  assign uart_tx = r_tx;

endmodule

// File: tb/tb_spi_to_uart_bridge.sv
// Randomised bench for spi_to_uart_bridge: an SPI master model drives bytes, a UART receiver model
// collects frames, and an in-order reference queue says which bytes must come out.
module tb_spi_to_uart_bridge;

  localparam int CLKS  = 160;
  localparam int DEPTH = 16;
  localparam int HALF  = 4;

  logic clk, rst, sclk, cs, mosi, miso, uart_tx;

  spi_to_uart_bridge #(.CLKS_PER_BIT(CLKS), .FIFO_DEPTH(DEPTH)) dut (
    .system_clk(clk), .rst(rst), .sclk(sclk), .cs(cs),
    .mosi(mosi), .miso(miso), .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int pass_cnt = 0;
  int check_cnt = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_reply;
  logic [7:0] mon_b;

  // UART receiver: samples each bit in its middle on the falling clock edge
  initial begin
    forever begin
      @(negedge uart_tx);
      repeat (CLKS/2) @(negedge clk);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CLKS) @(negedge clk);
          mon_b[i] = uart_tx;
        end
        repeat (CLKS) @(negedge clk);
        if (uart_tx !== 1'b1) frame_err++;
        rx_q.push_back(mon_b);
        $display("uart frame byte=%02h stop=%b", mon_b, uart_tx);
      end
    end
  end

  initial begin
    #(20 * 150000);
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    $display("spi xfer bits=%0d mosi=%02h miso=%02h", nbits, tx, rx);
  endtask

  task automatic spi_begin();
    cs = 1'b0;
  endtask

  task automatic spi_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (12*CLKS) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] rx;
    int lows;
    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (uart_tx !== 1'b1) $display("FAIL reset_uart_tx: got %b want 1", uart_tx); else pass_cnt++;
    check_cnt++;
    if (miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", miso); else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    spi_begin(); spi_bits(8'h5A, 8, rx); spi_end();
    spi_begin(); spi_bits(8'h77, 8, rx); spi_end();
    repeat (CLKS*4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cnt++;
    if (uart_tx !== 1'b1) $display("FAIL midframe_reset_uart_tx: got %b want 1", uart_tx); else pass_cnt++;
    check_cnt++;
    if (miso !== 1'b0) $display("FAIL midframe_reset_miso: got %b want 0", miso); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 12*CLKS; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    check_cnt++;
    if (lows != 0) $display("FAIL reset_no_frame: got %0d low cycles want 0", lows); else pass_cnt++;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
    model_reply = 8'h00;
  endtask

  task automatic test_single_byte();
    logic [7:0] rx;
    int n;
    spi_begin(); spi_bits(8'hA5, 8, rx); spi_end();
    check_cnt++;
    if (rx !== model_reply) $display("FAIL single_reply: got %02h want %02h", rx, model_reply); else pass_cnt++;
    model_reply = 8'hA5;
    exp_q.push_back(8'hA5);
    n = 0;
    while (uart_tx !== 1'b0 && n < 16) begin @(negedge clk); n++; end
    check_cnt++;
    if (uart_tx !== 1'b0) $display("FAIL single_start: got %b want 0", uart_tx); else pass_cnt++;
    n = 0;
    while (uart_tx === 1'b0 && n < 2*CLKS) begin @(negedge clk); n++; end
    n = 0;
    while (uart_tx === 1'b1 && n < 2*CLKS) begin @(negedge clk); n++; end
    check_cnt++;
    if (n < CLKS-1 || n > CLKS+1) $display("FAIL single_bit0_len: got %0d want %0d", n, CLKS); else pass_cnt++;
    n = 0;
    while (uart_tx === 1'b0 && n < 2*CLKS) begin @(negedge clk); n++; end
    check_cnt++;
    if (n < CLKS-1 || n > CLKS+1) $display("FAIL single_bit1_len: got %0d want %0d", n, CLKS); else pass_cnt++;
    wait_rx(exp_q.size(), 12*CLKS);
    check_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL single_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL single_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    check_cnt++;
    if (frame_err != 0) $display("FAIL single_stop: got %0d bad stops want 0", frame_err); else pass_cnt++;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  task automatic test_echo();
    logic [7:0] rx, third;
    third = 8'($urandom_range(0, 255));
    spi_begin(); spi_bits(8'h3C, 8, rx); spi_end();
    check_cnt++;
    if (rx !== model_reply) $display("FAIL echo_second: got %02h want %02h", rx, model_reply); else pass_cnt++;
    model_reply = 8'h3C;
    exp_q.push_back(8'h3C);
    spi_begin(); spi_bits(third, 8, rx); spi_end();
    check_cnt++;
    if (rx !== model_reply) $display("FAIL echo_third: got %02h want %02h", rx, model_reply); else pass_cnt++;
    model_reply = third;
    exp_q.push_back(third);
    wait_rx(exp_q.size(), 24*CLKS);
    check_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL echo_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL echo_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  // The whole burst lands well inside one UART frame, so capacity is the FIFO plus the shifter
  task automatic test_burst_overflow();
    logic [7:0] rx, tx;
    spi_begin();
    for (int k = 0; k < 20; k++) begin
      tx = 8'(k * 3);
      spi_bits(tx, 8, rx);
      check_cnt++;
      if (rx !== model_reply) $display("FAIL burst_reply[%0d]: got %02h want %02h", k, rx, model_reply); else pass_cnt++;
      model_reply = tx;
      if (k < DEPTH + 1) exp_q.push_back(tx);
    end
    spi_end();
    wait_rx(exp_q.size(), 20*10*CLKS);
    check_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL burst_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL burst_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    check_cnt++;
    if (frame_err != 0) $display("FAIL burst_stop: got %0d bad stops want 0", frame_err); else pass_cnt++;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  task automatic test_aborted_byte();
    logic [7:0] rx;
    spi_begin(); spi_bits(8'($urandom_range(0, 255)), 5, rx); spi_end();
    spi_begin(); spi_bits(8'h81, 8, rx); spi_end();
    check_cnt++;
    if (rx !== model_reply) $display("FAIL abort_reply: got %02h want %02h", rx, model_reply); else pass_cnt++;
    model_reply = 8'h81;
    exp_q.push_back(8'h81);
    wait_rx(exp_q.size(), 12*CLKS);
    check_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL abort_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL abort_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  // Bytes arrive faster than the UART drains them but never enough to reach capacity
  task automatic test_stream();
    logic [7:0] rx, tx;
    tx = 8'($urandom_range(0, 255));
    for (int k = 0; k < 16; k++) begin
      spi_begin(); spi_bits(tx, 8, rx); spi_end();
      check_cnt++;
      if (rx !== model_reply) $display("FAIL stream_reply[%0d]: got %02h want %02h", k, rx, model_reply); else pass_cnt++;
      model_reply = tx;
      exp_q.push_back(tx);
      tx = tx + 8'd1;
      repeat ($urandom_range(900, 1100)) @(negedge clk);
    end
    wait_rx(exp_q.size(), 16*10*CLKS);
    check_cnt++;
    if (rx_q.size() != exp_q.size()) $display("FAIL stream_count: got %0d want %0d", rx_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL stream_byte[%0d]: got %02h want %02h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    check_cnt++;
    if (frame_err != 0) $display("FAIL stream_stop: got %0d bad stops want 0", frame_err); else pass_cnt++;
    rx_q.delete(); exp_q.delete(); frame_err = 0;
  endtask

  initial begin
    model_reply = 8'h00;
    test_reset();
    test_single_byte();
    test_echo();
    test_burst_overflow();
    test_aborted_byte();
    test_stream();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
